// File: rtl/sram_rr_arbiter_1rw.sv
// Two-requester round-robin arbiter/sequencer for a single-port 1rw SRAM macro.
// Requests are granted combinationally, launched to the macro from registers,
// and answered with a one-cycle response strobe two cycles after acceptance.
module sram_rr_arbiter_1rw #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  // requester A
  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic                  a_req_we,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  input  logic [DATA_WIDTH-1:0] a_req_wdata,
  output logic                  a_resp_valid,
  output logic [DATA_WIDTH-1:0] a_resp_rdata,
  // requester B
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic                  b_req_we,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  input  logic [DATA_WIDTH-1:0] b_req_wdata,
  output logic                  b_resp_valid,
  output logic [DATA_WIDTH-1:0] b_resp_rdata,
  // SRAM macro port
  output logic                  mem_csb0,
  output logic                  mem_web0,
  output logic [ADDR_WIDTH-1:0] mem_addr0,
  output logic [DATA_WIDTH-1:0] mem_din0,
  input  logic [DATA_WIDTH-1:0] mem_dout0,
  // statistics
  output logic [CNT_WIDTH-1:0]  conflict_cnt
);

  // Stage 1 = macro command registers, stage 2 = macro access in progress.
  localparam int STAGES = 2;

  typedef struct packed {
    logic port_b;  // 1 = requester B owns this access
    logic we;
  } tag_t;

  logic                  ptr_b_q, ptr_b_d;   // 1 = B favoured on a tie
  logic                  a_gnt, b_gnt, accept;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  logic                  csb_q, web_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] din_q;

  logic [STAGES:1]       vld_pipe_q;
  tag_t [STAGES:1]       tag_q;

  logic                  a_rv_q, b_rv_q;
  logic [DATA_WIDTH-1:0] a_rd_q, b_rd_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  // Grant: a lone requester always wins; on a tie the pointer decides.
  always_comb begin
    a_gnt     = a_req_valid & (~b_req_valid | ~ptr_b_q);
    b_gnt     = b_req_valid & (~a_req_valid |  ptr_b_q);
    accept    = a_gnt | b_gnt;
    sel_we    = a_gnt ? a_req_we    : b_req_we;
    sel_addr  = a_gnt ? a_req_addr  : b_req_addr;
    sel_wdata = a_gnt ? a_req_wdata : b_req_wdata;
    ptr_b_d   = accept ? a_gnt : ptr_b_q;
  end

  // Round-robin pointer: after a grant, favour the requester that lost.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) ptr_b_q <= 1'b0;
    else         ptr_b_q <= ptr_b_d;
  end

  // Stage 1: macro command registers; addr/din hold when idle.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      csb_q  <= 1'b1;
      web_q  <= 1'b1;
      addr_q <= '0;
      din_q  <= '0;
    end else if (accept) begin
      csb_q  <= 1'b0;
      web_q  <= ~sel_we;
      addr_q <= sel_addr;
      din_q  <= sel_wdata;
    end else begin
      csb_q  <= 1'b1;
      web_q  <= 1'b1;
    end
  end

  // Tag pipeline tracking which requester owns each in-flight access.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      vld_pipe_q <= '0;
      tag_q      <= '0;
    end else begin
      vld_pipe_q[1] <= accept;
      tag_q[1]      <= '{port_b: b_gnt, we: sel_we};
      vld_pipe_q[2] <= vld_pipe_q[1];
      tag_q[2]      <= tag_q[1];
    end
  end

  // Response: strobe the owner and capture macro read data at the same edge.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      a_rv_q <= 1'b0;
      b_rv_q <= 1'b0;
      a_rd_q <= '0;
      b_rd_q <= '0;
    end else begin
      a_rv_q <= vld_pipe_q[2] & ~tag_q[2].port_b;
      b_rv_q <= vld_pipe_q[2] &  tag_q[2].port_b;
      if (vld_pipe_q[2] & ~tag_q[2].port_b & ~tag_q[2].we) a_rd_q <= mem_dout0;
      if (vld_pipe_q[2] &  tag_q[2].port_b & ~tag_q[2].we) b_rd_q <= mem_dout0;
    end
  end

  // Saturating count of cycles in which both requesters were valid.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n)
      cnt_q <= '0;
    else if (a_req_valid && b_req_valid && (cnt_q != {CNT_WIDTH{1'b1}}))
      cnt_q <= cnt_q + 1'b1;
  end

  assign a_req_ready  = a_gnt;
  assign b_req_ready  = b_gnt;
  assign mem_csb0     = csb_q;
  assign mem_web0     = web_q;
  assign mem_addr0    = addr_q;
  assign mem_din0     = din_q;
  assign a_resp_valid = a_rv_q;
  assign b_resp_valid = b_rv_q;
  assign a_resp_rdata = a_rd_q;
  assign b_resp_rdata = b_rd_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_sram_rr_arbiter_1rw.sv
// Bench for sram_rr_arbiter_1rw: a 32x4 1rw macro model drives mem_dout0, and a
// transaction-level model (grant rule, word array, response queue) predicts
// every DUT output cycle by cycle.
module tb_sram_rr_arbiter_1rw;
  localparam int DW = 4, AW = 5, CW = 8;

  logic          gclk = 1'b0;
  logic          grst_n;
  logic          a_req_valid, a_req_ready, a_req_we, a_resp_valid;
  logic [AW-1:0] a_req_addr;
  logic [DW-1:0] a_req_wdata, a_resp_rdata;
  logic          b_req_valid, b_req_ready, b_req_we, b_resp_valid;
  logic [AW-1:0] b_req_addr;
  logic [DW-1:0] b_req_wdata, b_resp_rdata;
  logic          mem_csb0, mem_web0;
  logic [AW-1:0] mem_addr0;
  logic [DW-1:0] mem_din0, mem_dout0;
  logic [CW-1:0] conflict_cnt;

  always #5 gclk = ~gclk;

  sram_rr_arbiter_1rw #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk0(gclk), .rst0_n(grst_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
    .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
    .a_resp_valid(a_resp_valid), .a_resp_rdata(a_resp_rdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
    .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
    .b_resp_valid(b_resp_valid), .b_resp_rdata(b_resp_rdata),
    .mem_csb0(mem_csb0), .mem_web0(mem_web0), .mem_addr0(mem_addr0),
    .mem_din0(mem_din0), .mem_dout0(mem_dout0), .conflict_cnt(conflict_cnt)
  );

  // ---- SRAM macro model: sample at posedge, write/read resolve at negedge
  logic [DW-1:0] sram [32];
  logic          m_pend, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;

  initial begin
    for (int i = 0; i < 32; i++) sram[i] = '0;
    m_pend = 1'b0; m_we = 1'b0; m_addr = '0; m_din = '0; mem_dout0 = '0;
  end

  always @(posedge gclk) begin
    m_pend = !mem_csb0;
    m_we   = !mem_web0;
    m_addr = mem_addr0;
    m_din  = mem_din0;
  end

  always @(negedge gclk) begin
    if (m_pend) begin
      if (m_we) sram[m_addr] = m_din;
      else      mem_dout0    = sram[m_addr];
    end
  end

  // ---- reference model
  typedef struct {
    bit            b;
    bit            we;
    logic [DW-1:0] data;
    int            due;
  } resp_t;

  resp_t         exp_q[$];
  logic [DW-1:0] ref_mem [32];
  bit            fav_b;
  int            ref_cnt;
  int            cyc;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_din, exp_ard, exp_brd;
  bit            exp_csb, exp_web;

  int vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    fav_b = 0; ref_cnt = 0;
    exp_addr = '0; exp_din = '0; exp_ard = '0; exp_brd = '0;
    exp_csb = 1; exp_web = 1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_csb", mem_csb0, 1);
    chk("rst_web", mem_web0, 1);
    chk("rst_addr", mem_addr0, 0);
    chk("rst_din", mem_din0, 0);
    chk("rst_arv", a_resp_valid, 0);
    chk("rst_brv", b_resp_valid, 0);
    chk("rst_ard", a_resp_rdata, 0);
    chk("rst_brd", b_resp_rdata, 0);
    chk("rst_cnt", conflict_cnt, 0);
  endtask

  // One clock of stimulus; called at a negedge and returns at the next one.
  task automatic step(input bit av, input bit awe, input int aaddr, input int adata,
                      input bit bv, input bit bwe, input int baddr, input int bdata);
    int    win;  // 0 none, 1 A, 2 B
    resp_t r;
    bit    ev_a, ev_b;
    a_req_valid = av; a_req_we = awe; a_req_addr = AW'(aaddr); a_req_wdata = DW'(adata);
    b_req_valid = bv; b_req_we = bwe; b_req_addr = AW'(baddr); b_req_wdata = DW'(bdata);
    #1;
    if (av && bv) win = fav_b ? 2 : 1;
    else if (av)  win = 1;
    else if (bv)  win = 2;
    else          win = 0;
    chk("a_ready", a_req_ready, win == 1);
    chk("b_ready", b_req_ready, win == 2);
    if (av && bv && ref_cnt < 255) ref_cnt++;
    if (win != 0) begin
      r.b  = (win == 2);
      r.we = r.b ? bwe : awe;
      exp_addr = r.b ? AW'(baddr) : AW'(aaddr);
      exp_din  = r.b ? DW'(bdata) : DW'(adata);
      if (r.we) ref_mem[exp_addr] = exp_din;
      r.data = ref_mem[exp_addr];
      r.due  = cyc + 3;
      exp_q.push_back(r);
      exp_csb = 0; exp_web = !r.we;
      fav_b = (win == 1);
    end else begin
      exp_csb = 1; exp_web = 1;
    end
    @(posedge gclk);
    cyc++;
    #1;
    ev_a = 0; ev_b = 0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      r = exp_q.pop_front();
      if (r.b) begin ev_b = 1; if (!r.we) exp_brd = r.data; end
      else     begin ev_a = 1; if (!r.we) exp_ard = r.data; end
    end
    chk("a_resp_valid", a_resp_valid, ev_a);
    chk("b_resp_valid", b_resp_valid, ev_b);
    chk("a_resp_rdata", a_resp_rdata, exp_ard);
    chk("b_resp_rdata", b_resp_rdata, exp_brd);
    chk("conflict_cnt", conflict_cnt, ref_cnt);
    chk("mem_csb0", mem_csb0, exp_csb);
    chk("mem_web0", mem_web0, exp_web);
    chk("mem_addr0", mem_addr0, exp_addr);
    chk("mem_din0", mem_din0, exp_din);
    @(negedge gclk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    cyc = 0;
    model_reset();
    grst_n = 0;
    a_req_valid = 0; a_req_we = 0; a_req_addr = '0; a_req_wdata = '0;
    b_req_valid = 0; b_req_we = 0; b_req_addr = '0; b_req_wdata = '0;
    repeat (3) @(negedge gclk);
    check_reset_outputs();
    grst_n = 1;

    // A write 5=A, then A read back with idle gap
    step(1, 1, 5, 4'hA, 0, 0, 0, 0);
    idle(3);
    step(1, 0, 5, 0, 0, 0, 0, 0);
    idle(4);
    chk("a_rdata_hold", a_resp_rdata, 4'hA);

    // preload 1=3, 2=C, then contending reads for 4 cycles
    step(1, 1, 1, 4'h3, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 2, 4'hC);
    idle(3);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 1, 0, 2, 0);
    idle(3);

    // back-to-back B write then read of addr 31
    step(0, 0, 0, 0, 1, 1, 31, 4'hF);
    step(0, 0, 0, 0, 1, 0, 31, 0);
    idle(3);
    chk("b_rdata_31", b_resp_rdata, 4'hF);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 15),
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 15));
    idle(3);

    // 300 cycles of contention: counter must pin at all-ones
    for (int i = 0; i < 300; i++)
      step(1, $urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 15),
           1, $urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 15));
    chk("cnt_saturated", conflict_cnt, 8'hFF);
    idle(3);

    // reset one cycle after a read accept: nothing may come back
    step(0, 0, 0, 0, 1, 0, 7, 0);
    grst_n = 0;
    a_req_valid = 0; b_req_valid = 0;
    #1;
    check_reset_outputs();
    model_reset();
    repeat (2) @(negedge gclk);
    grst_n = 1;
    idle(4);
    step(1, 0, 3, 0, 1, 0, 4, 0);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
